// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder; chained CHUNK-wide inside serial_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands added CHUNK bits per clock, LSB chunk first.
// Define SERIAL_ADD_SUB_EN to add the sub port (a - b as a + ~b + 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (clog2(NCH) < 1) ? 1 : clog2(NCH);

  state_t           state, next;
  logic [WIDTH-1:0] opa, opb, sumr, bload;
  logic [IW-1:0]    idx;
  logic             carry, coutr, ovfr, cload;
  logic             accept, last;
  logic [CHUNK-1:0] achunk, bchunk, s;
  logic [CHUNK:0]   c;

  assign accept = start && (state != RUN);
  assign last   = (idx == IW'(NCH - 1));

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction reuses the adder: invert B at capture and force the carry-in.
  always_comb begin
    bload = b;
    cload = cin;
    if (sub) begin
      bload = ~b;
      cload = 1'b1;
    end
  end
`else
  always_comb begin
    bload = b;
    cload = cin;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = RUN;
      RUN:     if (last) next = DONE;
      DONE:    next = accept ? RUN : IDLE;
      default: next = IDLE;
    endcase
  end

  assign achunk = opa[idx*CHUNK +: CHUNK];
  assign bchunk = opb[idx*CHUNK +: CHUNK];
  assign c[0]   = carry;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    fa_cell u_fa (
      .a  (achunk[i]),
      .b  (bchunk[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Result bits are cleared at launch, so unwritten chunks read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sumr  <= '0;
      coutr <= 1'b0;
      ovfr  <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= bload;
      carry <= cload;
      idx   <= '0;
      sumr  <= '0;
      coutr <= 1'b0;
      ovfr  <= 1'b0;
    end else if (state == RUN) begin
      sumr[idx*CHUNK +: CHUNK] <= s;
      carry <= c[CHUNK];
      if (last) begin
        idx   <= '0;
        coutr <= c[CHUNK];
        ovfr  <= c[CHUNK] ^ c[CHUNK-1];
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sumr;
  assign cout = coutr;
  assign ovf  = ovfr;

endmodule
